adc_frame_packer: RTL and testbench



---
 rtl/adc_frame_packer_if.sv | 21 ++
 rtl/adc_frame_packer.sv | 149 ++++++++++++++
 tb/tb_adc_frame_packer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_packer_if.sv
// FIFO read port plus byte-link handshake between the frame packer (master) and its environment (slave).
interface adc_frame_packer_if #(
    parameter int unsigned p_nbit_d = 16
);
    logic                fifo_rd;
    logic [p_nbit_d-1:0] fifo_rdata;
    logic                fifo_rempty;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (
        output fifo_rd, tx_data, tx_valid,
        input  fifo_rdata, fifo_rempty, tx_ready
    );

    modport slave (
        input  fifo_rd, tx_data, tx_valid,
        output fifo_rdata, fifo_rempty, tx_ready
    );
endinterface

// File: rtl/adc_frame_packer.sv
// Pops ADC samples from a pipelined FIFO read port and serialises them into
// framed bytes: A5 5A seq {sample MSB, LSB} x p_nsamp csum, over valid/ready.
module adc_frame_packer #(
    parameter int unsigned p_nbit_d = 16,
    parameter int unsigned p_nsamp  = 64,
    parameter int unsigned p_rd_lat = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                en,
    adc_frame_packer_if.master  bus,
    output logic                busy,
    output logic                frame_done
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LAT_W  = 2;
    localparam int unsigned SAMP_W = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_SEQ, S_FETCH, S_WAIT, S_BYTE_HI, S_BYTE_LO, S_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         seq_q, seq_d;
    logic [7:0]         csum_q, csum_d;
    logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [SAMP_W-1:0]  sample_q, sample_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               hs_c;
    logic               start_ok_c;

    assign hs_c        = tx_valid_q & bus.tx_ready;
    assign start_ok_c  = en & ~bus.fifo_rempty;
    assign bus.fifo_rd = (state_q == S_FETCH) & ~bus.fifo_rempty;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = frame_done_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q      <= S_IDLE;
            seq_q        <= '0;
            csum_q       <= '0;
            samp_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            sample_q     <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            csum_q       <= csum_d;
            samp_cnt_q   <= samp_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            sample_q     <= sample_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        csum_d       = csum_q;
        samp_cnt_d   = samp_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        sample_d     = sample_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_ok_c) begin
                    state_d    = S_HDR0;
                    csum_d     = '0;
                    samp_cnt_d = '0;
                end
            end
            S_HDR0: if (hs_c) state_d = S_HDR1;
            S_HDR1: if (hs_c) state_d = S_SEQ;
            S_SEQ: begin
                if (hs_c) begin
                    csum_d  = csum_q + seq_q;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!bus.fifo_rempty) begin
                    lat_cnt_d = LAT_W'(p_rd_lat);
                    state_d   = S_WAIT;
                end
            end
            // Count down the read latency; capture on the last WAIT edge.
            S_WAIT: begin
                if (lat_cnt_q == LAT_W'(1)) begin
                    sample_d = SAMP_W'(bus.fifo_rdata[p_nbit_d-1:0]);
                    state_d  = S_BYTE_HI;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_BYTE_HI: begin
                if (hs_c) begin
                    csum_d  = csum_q + sample_q[15:8];
                    state_d = S_BYTE_LO;
                end
            end
            S_BYTE_LO: begin
                if (hs_c) begin
                    csum_d     = csum_q + sample_q[7:0];
                    samp_cnt_d = samp_cnt_q + CNT_W'(1);
                    state_d    = (samp_cnt_d == CNT_W'(p_nsamp)) ? S_CSUM : S_FETCH;
                end
            end
            S_CSUM: begin
                if (hs_c) begin
                    frame_done_d = 1'b1;
                    seq_d        = seq_q + 8'd1;
                    if (start_ok_c) begin
                        state_d    = S_HDR0;
                        csum_d     = '0;
                        samp_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Byte register follows the state being entered, so it is stable while stalled.
        unique case (state_d)
            S_HDR0:    begin tx_valid_d = 1'b1; tx_data_d = 8'hA5;           end
            S_HDR1:    begin tx_valid_d = 1'b1; tx_data_d = 8'h5A;           end
            S_SEQ:     begin tx_valid_d = 1'b1; tx_data_d = seq_d;           end
            S_BYTE_HI: begin tx_valid_d = 1'b1; tx_data_d = sample_d[15:8];  end
            S_BYTE_LO: begin tx_valid_d = 1'b1; tx_data_d = sample_d[7:0];   end
            S_CSUM:    begin tx_valid_d = 1'b1; tx_data_d = csum_d;          end
            default:   begin tx_valid_d = 1'b0; tx_data_d = tx_data_q;       end
        endcase
    end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: three instances (lat 2/1/3) each fed by a queue-based FIFO model.
module tb_adc_frame_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_a, en_b, en_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    int   checks = 0;
    int   failures = 0;

    adc_frame_packer_if #(.p_nbit_d(16)) ifa ();
    adc_frame_packer_if #(.p_nbit_d(16)) ifb ();
    adc_frame_packer_if #(.p_nbit_d(12)) ifc ();

    adc_frame_packer #(.p_nbit_d(16), .p_nsamp(4), .p_rd_lat(2)) dut_a (
        .rclk(clk), .rrst_n(rst_n), .en(en_a), .bus(ifa), .busy(busy_a), .frame_done(done_a));
    adc_frame_packer #(.p_nbit_d(16), .p_nsamp(1), .p_rd_lat(1)) dut_b (
        .rclk(clk), .rrst_n(rst_n), .en(en_b), .bus(ifb), .busy(busy_b), .frame_done(done_b));
    adc_frame_packer #(.p_nbit_d(12), .p_nsamp(2), .p_rd_lat(3)) dut_c (
        .rclk(clk), .rrst_n(rst_n), .en(en_c), .bus(ifc), .busy(busy_c), .frame_done(done_c));

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [11:0] q_c[$];
    logic [7:0]  bytes_a[$];
    logic [7:0]  bytes_b[$];
    logic [7:0]  bytes_c[$];
    logic [15:0] pipe_a;
    logic [11:0] pipe_c1, pipe_c2;
    int rd_a = 0, rd_b = 0, rd_c = 0, rd_err = 0;
    int ndone_a = 0, ndone_b = 0, ndone_c = 0;
    int nbusy_a = 0, nbusy_b = 0, nbusy_c = 0;
    int unstable = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // FIFO models: data appears p_rd_lat-1 edges after the edge that samples fifo_rd.
    always @(posedge clk) begin
        if (ifa.fifo_rd) begin
            if (q_a.size() == 0) rd_err <= rd_err + 1; else pipe_a <= q_a.pop_front();
            rd_a <= rd_a + 1;
        end
        ifa.fifo_rdata  <= pipe_a;
        ifa.fifo_rempty <= (q_a.size() == 0);
    end
    always @(posedge clk) begin
        if (ifb.fifo_rd) begin
            if (q_b.size() == 0) rd_err <= rd_err + 1; else ifb.fifo_rdata <= q_b.pop_front();
            rd_b <= rd_b + 1;
        end
        ifb.fifo_rempty <= (q_b.size() == 0);
    end
    always @(posedge clk) begin
        if (ifc.fifo_rd) begin
            if (q_c.size() == 0) rd_err <= rd_err + 1; else pipe_c1 <= q_c.pop_front();
            rd_c <= rd_c + 1;
        end
        pipe_c2         <= pipe_c1;
        ifc.fifo_rdata  <= pipe_c2;
        ifc.fifo_rempty <= (q_c.size() == 0);
    end

    // Link monitors: accepted bytes, frame_done pulses, busy cycles, stall stability.
    always @(posedge clk) begin
        if (ifa.tx_valid && ifa.tx_ready) bytes_a.push_back(ifa.tx_data);
        if (ifb.tx_valid && ifb.tx_ready) bytes_b.push_back(ifb.tx_data);
        if (ifc.tx_valid && ifc.tx_ready) bytes_c.push_back(ifc.tx_data);
        if (done_a) ndone_a <= ndone_a + 1;
        if (done_b) ndone_b <= ndone_b + 1;
        if (done_c) ndone_c <= ndone_c + 1;
        if (busy_a) nbusy_a <= nbusy_a + 1;
        if (busy_b) nbusy_b <= nbusy_b + 1;
        if (busy_c) nbusy_c <= nbusy_c + 1;
        if (prev_stall && !(ifa.tx_valid && ifa.tx_data == prev_data)) unstable <= unstable + 1;
        prev_stall <= ifa.tx_valid & ~ifa.tx_ready;
        prev_data  <= ifa.tx_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] got[$], input int base,
                             input logic [7:0] exp[$]);
        foreach (exp[i])
            chk($sformatf("%s_b%0d", tag, i),
                (base + i < got.size()) ? 32'(got[base + i]) : 32'hDEAD_BEEF, 32'(exp[i]));
    endtask

    function automatic int done_of(input int which);
        return (which == 0) ? ndone_a : (which == 1) ? ndone_b : ndone_c;
    endfunction

    task automatic wait_done(input string tag, input int which, input int target, input int budget);
        for (int n = 0; n < budget && done_of(which) < target; n++) @(negedge clk);
        chk({tag, "_done_reached"}, 32'(done_of(which) >= target), 32'd1);
    endtask

    initial begin
        logic [7:0] exp[$];
        int b0, r0, d0, n0, bad;

        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        ifa.tx_ready = 1'b1; ifb.tx_ready = 1'b1; ifc.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(ifa.tx_data), 32'd0);
        chk("rst_fifo_rd", 32'(ifa.fifo_rd), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_frame_done", 32'(done_a), 32'd0);

        // Basic frame
        q_a.push_back(16'h0102); q_a.push_back(16'h0304);
        q_a.push_back(16'h0506); q_a.push_back(16'h0708);
        repeat (2) @(negedge clk);
        b0 = bytes_a.size(); r0 = rd_a; n0 = nbusy_a;
        en_a = 1'b1;
        wait_done("basic", 0, 1, 200);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        chk("basic_len", 32'(bytes_a.size() - b0), 32'd12);
        chk_frame("basic", bytes_a, b0, exp);
        chk("basic_reads", 32'(rd_a - r0), 32'd4);
        chk("basic_done_pulses", 32'(ndone_a), 32'd1);
        chk("basic_busy_cycles", 32'(nbusy_a - n0), 32'd24);
        chk("basic_idle", 32'(busy_a), 32'd0);

        // Backpressure at 30% ready; en dropped during sample 1; a spare sample stays queued
        q_a.push_back(16'h0102); q_a.push_back(16'h0304); q_a.push_back(16'h0506);
        q_a.push_back(16'h0708); q_a.push_back(16'h0909);
        repeat (2) @(negedge clk);
        b0 = bytes_a.size(); r0 = rd_a; d0 = ndone_a;
        en_a = 1'b1;
        for (int n = 0; n < 3000 && ndone_a < d0 + 1; n++) begin
            @(negedge clk);
            ifa.tx_ready = ($urandom_range(0, 9) < 3);
            if (bytes_a.size() - b0 >= 3) en_a = 1'b0;
        end
        chk("bp_done_reached", 32'(ndone_a >= d0 + 1), 32'd1);
        ifa.tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        exp = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h25};
        chk("bp_len", 32'(bytes_a.size() - b0), 32'd12);
        chk_frame("bp", bytes_a, b0, exp);
        chk("bp_reads", 32'(rd_a - r0), 32'd4);
        chk("bp_stable_while_stalled", 32'(unstable), 32'd0);
        chk("en_low_returns_idle", 32'(busy_a), 32'd0);
        chk("en_low_leaves_sample", 32'(q_a.size()), 32'd1);

        // Underrun: two samples available, the rest arrive 50 cycles later
        q_a.push_back(16'h0A0A);
        repeat (2) @(negedge clk);
        b0 = bytes_a.size(); d0 = ndone_a;
        en_a = 1'b1;
        for (int n = 0; n < 200 && bytes_a.size() - b0 < 7; n++) @(negedge clk);
        chk("ur_reached_fetch", 32'(bytes_a.size() - b0), 32'd7);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!(busy_a && !ifa.tx_valid && !ifa.fifo_rd)) bad++;
        end
        chk("ur_stall_in_fetch", 32'(bad), 32'd0);
        q_a.push_back(16'h0B0B); q_a.push_back(16'h0C0C);
        wait_done("ur", 0, d0 + 1, 200);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        exp = '{8'hA5, 8'h5A, 8'h02, 8'h09, 8'h09, 8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0C, 8'h0C, 8'h56};
        chk("ur_len", 32'(bytes_a.size() - b0), 32'd12);
        chk_frame("ur", bytes_a, b0, exp);

        // Seq wrap with back-to-back single-sample frames at lat 1
        for (int k = 0; k < 257; k++) q_b.push_back(16'h00FF);
        repeat (2) @(negedge clk);
        en_b = 1'b1;
        wait_done("wrap", 1, 257, 4000);
        en_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_len", 32'(bytes_b.size()), 32'(257 * 6));
        chk("wrap_reads", 32'(rd_b), 32'd257);
        chk("wrap_busy_cycles", 32'(nbusy_b), 32'(257 * 8));
        for (int k = 0; k < 257; k++) begin
            logic [7:0] s;
            s = 8'(k);
            exp = '{8'hA5, 8'h5A, s, 8'h00, 8'hFF, 8'(s + 8'hFF)};
            chk_frame($sformatf("wrap_f%0d", k), bytes_b, k * 6, exp);
        end

        // Lat 3 with 12-bit samples zero-extended
        q_c.push_back(12'hABC); q_c.push_back(12'h123);
        repeat (2) @(negedge clk);
        en_c = 1'b1;
        wait_done("lat3", 2, 1, 200);
        en_c = 1'b0;
        repeat (3) @(negedge clk);
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'hEA};
        chk("lat3_len", 32'(bytes_c.size()), 32'd8);
        chk_frame("lat3", bytes_c, 0, exp);
        chk("lat3_busy_cycles", 32'(nbusy_c), 32'd16);

        // Reset during BYTE_LO of sample 2, then restart
        q_a.push_back(16'h0102); q_a.push_back(16'h0304);
        q_a.push_back(16'h0506); q_a.push_back(16'h0708);
        repeat (2) @(negedge clk);
        b0 = bytes_a.size();
        en_a = 1'b1;
        for (int n = 0; n < 200 && bytes_a.size() - b0 < 6; n++) @(negedge clk);
        chk("mid_reached_byte_lo", 32'(ifa.tx_data), 32'h04);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
        chk("mid_rst_tx_data", 32'(ifa.tx_data), 32'd0);
        chk("mid_rst_fifo_rd", 32'(ifa.fifo_rd), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_frame_done", 32'(done_a), 32'd0);
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q_a.push_back(16'h1111); q_a.push_back(16'h2222);
        repeat (2) @(negedge clk);
        b0 = bytes_a.size(); d0 = ndone_a; r0 = rd_a;
        en_a = 1'b1;
        wait_done("restart", 0, d0 + 1, 200);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h11, 8'h11, 8'h22, 8'h22, 8'h80};
        chk("restart_len", 32'(bytes_a.size() - b0), 32'd12);
        chk_frame("restart", bytes_a, b0, exp);
        chk("restart_reads", 32'(rd_a - r0), 32'd4);
        chk("no_read_while_empty", 32'(rd_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
